// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM serial-to-parallel demultiplexer.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a trailing even-parity slot).
package tdm_pkg;

    // Slots per frame: data lanes, plus one parity slot when enabled.
    function automatic int unsigned tdm_slot_count(input int unsigned n);
`ifdef TDM_DEMUX_PARITY_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

    // Width of the slot index for a given lane count.
    function automatic int unsigned tdm_slot_w(input int unsigned n);
        return $clog2(tdm_slot_count(n));
    endfunction

    localparam int unsigned TDM_N     = 8;
    localparam int unsigned TDM_SLOTS = tdm_slot_count(TDM_N);
    localparam int unsigned TDM_SELW  = tdm_slot_w(TDM_N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: enable, synchronous load-to-1, explicit wrap at LAST, terminal-count flag.
module tdm_slot_ctr #(
    parameter int unsigned W    = 3,
    parameter int unsigned LAST = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load1,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    // Terminal count: the slot that completes the frame.
    always_comb begin
        tc_c = (cnt == W'(LAST));
    end

    // Count register; load has priority so a restarted frame lands on slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= W'(1);
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: steers one bit per valid cycle into its lane,
// delivers the completed word and flags early frame starts.
// Optional feature macro: TDM_DEMUX_PARITY_EN (extra even-parity slot, par_err pulse).
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned N    = TDM_N,
    parameter int unsigned SELW = tdm_slot_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din,
    input  logic            din_valid,
    input  logic            frame_start,
    output logic [N-1:0]    out,
    output logic            out_valid,
    output logic [SELW-1:0] slot,
    output logic            frame_err,
    output logic            par_err
);

    localparam int unsigned SLOTS = tdm_slot_count(N);

    tdm_state_t   state, state_nxt;
    logic [N-1:0] shadow, shadow_nxt;
    logic [N-1:0] out_nxt;
    logic         out_valid_nxt;
    logic         frame_err_nxt;
    logic         ctr_en;
    logic         ctr_load;
    logic         slot_tc_c;
`ifdef TDM_DEMUX_PARITY_EN
    logic         par_err_nxt;
`endif

    tdm_slot_ctr #(
        .W    (SELW),
        .LAST (SLOTS - 1)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctr_en),
        .load1 (ctr_load),
        .cnt   (slot),
        .tc_c  (slot_tc_c)
    );

    // State and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
        end
    end

    // Next-state, shadow update and output next values.
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        out_nxt       = out;
        out_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        ctr_en        = 1'b0;
        ctr_load      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (din_valid && frame_start) begin
                    shadow_nxt    = '0;
                    shadow_nxt[0] = din;
                    ctr_load      = 1'b1;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (frame_start) begin
                        // Slot is never 0 in RUN, so any mark here is early.
                        frame_err_nxt = 1'b1;
                        shadow_nxt    = '0;
                        shadow_nxt[0] = din;
                        ctr_load      = 1'b1;
                    end else begin
                        ctr_en = 1'b1;
                        for (int unsigned i = 0; i < N; i++) begin
                            if (slot == SELW'(i)) begin
                                shadow_nxt[i] = din;
                            end
                        end
                        if (slot_tc_c) begin
                            out_nxt       = shadow_nxt;
                            out_valid_nxt = 1'b1;
                            state_nxt     = IDLE;
`ifdef TDM_DEMUX_PARITY_EN
                            par_err_nxt   = (^shadow) ^ din;
`endif
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs; out holds between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Parity error pulse, aligned with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_nxt;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N = 8); the parity scenario runs when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;
    import tdm_pkg::*;

    localparam int unsigned N    = 8;
    localparam int unsigned SELW = tdm_slot_w(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            din;
    logic            din_valid;
    logic            frame_start;
    logic [N-1:0]    out;
    logic            out_valid;
    logic [SELW-1:0] slot;
    logic            frame_err;
    logic            par_err;

    int checks = 0;
    int errors = 0;

    tdm_demux #(.N(N), .SELW(SELW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .slot        (slot),
        .frame_err   (frame_err),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic d, input logic fs);
        @(negedge clk);
        din_valid   = v;
        din         = d;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    // Send bits lo..hi of w, marking the first one with frame_start if requested.
    task automatic send_bits(input logic [N-1:0] w, input int lo, input int hi, input logic mark);
        for (int i = lo; i <= hi; i++) begin
            step(1'b1, w[i], mark && (i == lo));
        end
    endtask

    initial begin
        logic [N-1:0] w;
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
        // 8'h03 has even parity bit 0.
        w = 8'h03;
        send_bits(w, 0, 7, 1'b1);
        check("par_slot_after_data", 32'(slot), 32'd8);
        check("par_no_early_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("par_ok_valid", 32'(out_valid), 32'h1);
        check("par_ok_out", 32'(out), 32'h03);
        check("par_ok_err", 32'(par_err), 32'h0);
        check("par_ok_slot", 32'(slot), 32'h0);
        send_bits(w, 0, 7, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        check("par_bad_valid", 32'(out_valid), 32'h1);
        check("par_bad_err", 32'(par_err), 32'h1);
        check("par_bad_out", 32'(out), 32'h03);
        step(1'b0, 1'b0, 1'b0);
        check("par_err_pulse_end", 32'(par_err), 32'h0);
        check("par_valid_pulse_end", 32'(out_valid), 32'h0);
`else
        // Unmarked bits after reset are discarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("unmarked_slot", 32'(slot), 32'h0);
            check("unmarked_valid", 32'(out_valid), 32'h0);
        end

        // Basic frame 1,1,0,0,0,0,0,0 -> 8'h03.
        w = 8'h03;
        step(1'b1, w[0], 1'b1);
        check("f1_slot_after_start", 32'(slot), 32'h1);
        send_bits(w, 1, 6, 1'b0);
        check("f1_slot7", 32'(slot), 32'h7);
        check("f1_no_early_valid", 32'(out_valid), 32'h0);
        send_bits(w, 7, 7, 1'b0);
        check("f1_valid", 32'(out_valid), 32'h1);
        check("f1_out", 32'(out), 32'h03);
        check("f1_slot_wrap", 32'(slot), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        check("f1_valid_pulse", 32'(out_valid), 32'h0);
        check("f1_out_hold", 32'(out), 32'h03);

        // Gap of 3 invalid cycles after slot 4.
        send_bits(w, 0, 4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check("gap_slot_hold", 32'(slot), 32'h5);
            check("gap_no_valid", 32'(out_valid), 32'h0);
        end
        send_bits(w, 5, 6, 1'b0);
        check("gap_no_valid_slot6", 32'(out_valid), 32'h0);
        send_bits(w, 7, 7, 1'b0);
        check("gap_valid", 32'(out_valid), 32'h1);
        check("gap_out", 32'(out), 32'h03);

        // Early frame_start at slot 5 drops the partial 8'hFF frame.
        w = 8'hFF;
        send_bits(w, 0, 4, 1'b1);
        check("err_slot5", 32'(slot), 32'h5);
        w = 8'h5A;
        step(1'b1, w[0], 1'b1);
        check("err_pulse", 32'(frame_err), 32'h1);
        check("err_slot_restart", 32'(slot), 32'h1);
        check("err_no_valid", 32'(out_valid), 32'h0);
        send_bits(w, 1, 1, 1'b0);
        check("err_pulse_end", 32'(frame_err), 32'h0);
        send_bits(w, 2, 7, 1'b0);
        check("err_new_valid", 32'(out_valid), 32'h1);
        check("err_new_out", 32'(out), 32'h5A);

        // frame_start on the slot N-1 bit is early, no delivery.
        w = 8'h00;
        send_bits(w, 0, 6, 1'b1);
        w = 8'h81;
        step(1'b1, w[0], 1'b1);
        check("late_err_pulse", 32'(frame_err), 32'h1);
        check("late_no_valid", 32'(out_valid), 32'h0);
        check("late_out_hold", 32'(out), 32'h5A);
        check("late_slot", 32'(slot), 32'h1);
        send_bits(w, 1, 7, 1'b0);
        check("late_new_valid", 32'(out_valid), 32'h1);
        check("late_new_out", 32'(out), 32'h81);

        // Back-to-back frame: start right after completion, no error.
        w = 8'h42;
        step(1'b1, w[0], 1'b1);
        check("b2b_no_err", 32'(frame_err), 32'h0);
        check("b2b_slot", 32'(slot), 32'h1);
        send_bits(w, 1, 7, 1'b0);
        check("b2b_valid", 32'(out_valid), 32'h1);
        check("b2b_out", 32'(out), 32'h42);

        // Asynchronous reset mid-frame at slot 6.
        w = 8'hFF;
        send_bits(w, 0, 5, 1'b1);
        check("mid_slot6", 32'(slot), 32'h6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(out), 32'h0);
        check("mid_rst_slot", 32'(slot), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(w, 6, 7, 1'b0);
        check("post_rst_unmarked_slot", 32'(slot), 32'h0);
        check("post_rst_unmarked_valid", 32'(out_valid), 32'h0);
        w = 8'hA5;
        send_bits(w, 0, 7, 1'b1);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_out", 32'(out), 32'hA5);
        check("par_err_tied", 32'(par_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Serial-to-parallel time-division demultiplexer: the receive end of the 8:1 `mux` select-sweep link. It accepts one bit per valid cycle from a 1-bit line whose source is swept through select values 0..N-1. It steers each bit into lane `slot`, registers the completed word and flags framing errors. It sits between the serial link and the parallel lane consumers.

## Interface
- `N`, default 8: number of lanes/slots per frame; power of two, at least 2.
- `SELW`, default $clog2(N): slot index width.
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is valid this cycle; when low, the slot does not advance.
- `frame_start` in 1: qualified by `din_valid`; marks the bit on `din` as slot 0.
- `out` out N: last completed word; bit s = bit received in slot s.
- `out_valid` out 1: one-cycle pulse; `out` updated this cycle.
- `slot` out SELW: slot index the next valid bit will fill.
- `frame_err` out 1: one-cycle pulse on an early `frame_start`.
- `par_err` out 1: one-cycle pulse on parity mismatch; only with the parity macro, else tied 0.

## Operation
- The FSM has two states, IDLE and RUN.
- IDLE:
  - Valid bits without `frame_start` are discarded.
  - `din_valid` and `frame_start` together: bit goes to shadow[0], `slot` becomes 1, next state is RUN.
- RUN, on `din_valid`:
  - The bit goes to shadow[`slot`] and `slot` increments.
  - The bit in slot N-1 completes the frame. `out` <= shadow with bit N-1 merged in, and `out_valid` pulses.
  - After the frame completes, `slot` becomes 0 and the state returns to IDLE. Each frame must be re-marked by `frame_start`.
- RUN with `din_valid` low: hold the shadow register and `slot`; no gap limit applies.
- `frame_start` while RUN with `slot` != 0:
  - `frame_err` pulses and the partial frame is discarded.
  - The current bit is taken as slot 0, `slot` becomes 1, and the state stays RUN.
- `frame_start` on the bit that fills slot N-1 is also early. It takes the `frame_err` path and `out_valid` does not pulse.
- `out` holds its value between frames; it is never cleared except by reset.
- `slot` arithmetic is SELW-bit. Wrap from N-1 to 0 is explicit, never by overflow alone.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `slot` = 0, `frame_err` = 0, `par_err` = 0, state IDLE, shadow = 0.
- Latency: the slot N-1 bit is sampled at edge k, and `out`/`out_valid` are visible after edge k. All outputs are registered.
- Minimum frame is N consecutive valid cycles. Back-to-back frames are allowed: a `frame_start` in the cycle after completion is accepted from IDLE with no error.
- Reset asserted mid-frame clears everything immediately and asynchronously. The first frame after release needs `frame_start`.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - The frame is N+1 slots. Slot N carries even parity over the N data bits.
  - `slot` is widened to $clog2(N+1) bits.
  - `out`/`out_valid` update when the parity bit is received, not earlier.
  - `par_err` pulses in the same cycle as `out_valid` on a mismatch. The word is still delivered.
- Not defined: frame is N slots, `par_err` is constant 0, and there is no extra logic.

## Structure
- Package `tdm_pkg` holds:
  - default `N` and `SELW`;
  - the state enum `tdm_state_t` (IDLE, RUN);
  - the slot-count localparam derived from `TDM_DEMUX_PARITY_EN`.
- Sub-module `tdm_slot_ctr` provides the slot counter with enable, synchronous load-to-1, wrap and terminal-count flag. The top level holds the FSM, shadow register and output registers.

## Test plan
- Stream 1,1,0,0,0,0,0,0 with `frame_start` on the first bit -> `out` = 8'h03, one `out_valid` pulse the cycle after the 8th bit.
- Same stream with `din_valid` low for 3 cycles after slot 4 -> `slot` holds at 5, `out` = 8'h03, `out_valid` is delayed by 3 cycles.
- `frame_start` again at slot 5 -> `frame_err` pulses once, the partial frame is dropped, and the next 8 bits produce their own word.
- Bits without `frame_start` after reset -> `out_valid` never asserts and `slot` stays 0.
- `rst_n` low at slot 6 -> all outputs return to 0 at once; a fresh frame of 8'hA5 then yields `out` = 8'hA5.
- With `TDM_DEMUX_PARITY_EN`: 8'h03 plus parity 0 -> `par_err` = 0; 8'h03 plus parity 1 -> `par_err` and `out_valid` pulse together and `out` = 8'h03.
